// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_unit
// Description : Program-counter stage for instruction fetch. Holds the PC,
//               selects the next PC (sequential, jump or taken branch) and
//               freezes while instruction memory reports busywait. The
//               redirect controls seen when a stall begins are captured and
//               applied when the stall releases.
// Ports       : clk         - system clock, all state updates on posedge
//               reset       - synchronous active-high reset
//               busywait    - instruction memory not ready, freeze PC
//               jump        - unconditional jump for current instruction
//               branch      - beq-style conditional branch
//               zero        - ALU zero flag (branch taken when branch & zero)
//               offset      - signed word offset (OFF_W bits)
//               pc          - current fetch address
//               pc_plus4    - pc + 4, combinational
//               fetch_valid - pc is a valid fetch request this cycle
//               state       - debug FSM state: 0 BOOT, 1 RUN, 2 WAIT
// Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_unit #(
    parameter int                PC_W     = 32,
    parameter int                OFF_W    = 8,
    parameter logic [PC_W-1:0]   RESET_PC = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             busywait,
    input  logic             jump,
    input  logic             branch,
    input  logic             zero,
    input  logic [OFF_W-1:0] offset,
    output logic [PC_W-1:0]  pc,
    output logic [PC_W-1:0]  pc_plus4,
    output logic             fetch_valid,
    output logic [1:0]       state
);

    localparam logic [1:0]      c_BOOT = 2'd0;
    localparam logic [1:0]      c_RUN  = 2'd1;
    localparam logic [1:0]      c_WAIT = 2'd2;
    localparam logic [PC_W-1:0] c_FOUR = PC_W'(4);

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [PC_W-1:0]  r_pc;

    // Controls captured on the edge where a stall begins
    logic             r_jump;
    logic             r_branch;
    logic             r_zero;
    logic [OFF_W-1:0] r_offset;

    logic             w_fetch_valid;
    logic             w_pc_load;
    logic             w_capture;
    logic             w_use_stored;

    logic             w_jump;
    logic             w_branch;
    logic             w_zero;
    logic [OFF_W-1:0] w_offset;
    logic [PC_W-1:0]  w_off_sext;
    logic [PC_W-1:0]  w_off_bytes;
    logic [PC_W-1:0]  w_pc_plus4;
    logic [PC_W-1:0]  w_target;
    logic [PC_W-1:0]  w_next_pc;
    logic             w_take;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_BOOT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_BOOT:  w_state_next = c_RUN;
            c_RUN:   if (busywait)  w_state_next = c_WAIT;
            c_WAIT:  if (!busywait) w_state_next = c_RUN;
            default: w_state_next = c_BOOT;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_fetch_valid = 1'b0;
        w_pc_load     = 1'b0;
        w_capture     = 1'b0;
        w_use_stored  = 1'b0;
        case (r_state)
            c_RUN: begin
                w_fetch_valid = 1'b1;
                w_capture     = busywait;
                w_pc_load     = !busywait;
            end
            c_WAIT: begin
                w_fetch_valid = 1'b1;
                w_use_stored  = 1'b1;
                w_pc_load     = !busywait;
            end
            default: begin
                w_fetch_valid = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Next-PC datapath. While waiting, decode may already show the next
    // instruction's controls, so the captured copy drives the redirect.
    // ------------------------------------------------------------------
    assign w_jump   = w_use_stored ? r_jump   : jump;
    assign w_branch = w_use_stored ? r_branch : branch;
    assign w_zero   = w_use_stored ? r_zero   : zero;
    assign w_offset = w_use_stored ? r_offset : offset;

    assign w_off_sext  = {{(PC_W-OFF_W){w_offset[OFF_W-1]}}, w_offset};
    assign w_off_bytes = {w_off_sext[PC_W-3:0], 2'b00};
    assign w_pc_plus4  = r_pc + c_FOUR;
    // Adds wrap modulo 2^PC_W by construction
    assign w_target    = w_pc_plus4 + w_off_bytes;
    assign w_take      = w_jump | (w_branch & w_zero);
    assign w_next_pc   = w_take ? w_target : w_pc_plus4;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else if (w_pc_load) begin
            r_pc <= w_next_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_jump   <= 1'b0;
            r_branch <= 1'b0;
            r_zero   <= 1'b0;
            r_offset <= '0;
        end else if (w_capture) begin
            r_jump   <= jump;
            r_branch <= branch;
            r_zero   <= zero;
            r_offset <= offset;
        end
    end

    assign pc          = r_pc;
    assign pc_plus4    = w_pc_plus4;
    assign fetch_valid = w_fetch_valid;
    assign state       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_fetch_unit
// Description : Directed self-checking bench for pc_fetch_unit. Each task
//               applies a table of input vectors, one per clock edge, and
//               compares pc, pc_plus4, state and fetch_valid after the edge
//               against hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_unit;

    localparam int PC_W  = 32;
    localparam int OFF_W = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             busywait;
    logic             jump;
    logic             branch;
    logic             zero;
    logic [OFF_W-1:0] offset;
    logic [PC_W-1:0]  pc;
    logic [PC_W-1:0]  pc_plus4;
    logic             fetch_valid;
    logic [1:0]       state;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic             rst;
        logic             bw;
        logic             j;
        logic             b;
        logic             z;
        logic [OFF_W-1:0] off;
        logic [PC_W-1:0]  exp_pc;
        logic [1:0]       exp_st;
        logic             exp_fv;
    } vec_t;

    pc_fetch_unit #(
        .PC_W     (PC_W),
        .OFF_W    (OFF_W),
        .RESET_PC (32'h0)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .busywait    (busywait),
        .jump        (jump),
        .branch      (branch),
        .zero        (zero),
        .offset      (offset),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .fetch_valid (fetch_valid),
        .state       (state)
    );

    always #5 clk = ~clk;

    task automatic apply(input vec_t v);
        reset    = v.rst;
        busywait = v.bw;
        jump     = v.j;
        branch   = v.b;
        zero     = v.z;
        offset   = v.off;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        vec_t v[4];
        v = '{
            '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0000_0000, 2'd0, 1'b0},
            '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0000_0000, 2'd1, 1'b1},
            '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0000_0004, 2'd1, 1'b1},
            '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0000_0008, 2'd1, 1'b1}
        };
        for (int i = 0; i < 4; i++) begin
            apply(v[i]);
            checks++;
            if ({pc, pc_plus4, state, fetch_valid} !==
                {v[i].exp_pc, v[i].exp_pc + 32'd4, v[i].exp_st, v[i].exp_fv}) begin
                failures++;
                $display("FAIL reset[%0d]: pc=%h p4=%h st=%0d fv=%b, want pc=%h p4=%h st=%0d fv=%b",
                         i, pc, pc_plus4, state, fetch_valid,
                         v[i].exp_pc, v[i].exp_pc + 32'd4, v[i].exp_st, v[i].exp_fv);
            end
        end
    endtask

    task automatic test_jump;
        vec_t v[5];
        v = '{
            '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0000_000C, 2'd1, 1'b1},
            '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0000_0010, 2'd1, 1'b1},
            '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h03, 32'h0000_0020, 2'd1, 1'b1},
            '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFE, 32'h0000_001C, 2'd1, 1'b1},
            '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0000_0020, 2'd1, 1'b1}
        };
        for (int i = 0; i < 5; i++) begin
            apply(v[i]);
            checks++;
            if ({pc, pc_plus4, state, fetch_valid} !==
                {v[i].exp_pc, v[i].exp_pc + 32'd4, v[i].exp_st, v[i].exp_fv}) begin
                failures++;
                $display("FAIL jump[%0d]: pc=%h p4=%h st=%0d fv=%b, want pc=%h p4=%h st=%0d fv=%b",
                         i, pc, pc_plus4, state, fetch_valid,
                         v[i].exp_pc, v[i].exp_pc + 32'd4, v[i].exp_st, v[i].exp_fv);
            end
        end
    endtask

    task automatic test_branch;
        vec_t v[7];
        v = '{
            '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h02, 32'h0000_0024, 2'd1, 1'b1},
            '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFE, 32'h0000_0020, 2'd1, 1'b1},
            '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h02, 32'h0000_002C, 2'd1, 1'b1},
            '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFC, 32'h0000_0020, 2'd1, 1'b1},
            '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h01, 32'h0000_0028, 2'd1, 1'b1},
            '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h05, 32'h0000_002C, 2'd1, 1'b1},
            '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0000_0030, 2'd1, 1'b1}
        };
        for (int i = 0; i < 7; i++) begin
            apply(v[i]);
            checks++;
            if ({pc, pc_plus4, state, fetch_valid} !==
                {v[i].exp_pc, v[i].exp_pc + 32'd4, v[i].exp_st, v[i].exp_fv}) begin
                failures++;
                $display("FAIL branch[%0d]: pc=%h p4=%h st=%0d fv=%b, want pc=%h p4=%h st=%0d fv=%b",
                         i, pc, pc_plus4, state, fetch_valid,
                         v[i].exp_pc, v[i].exp_pc + 32'd4, v[i].exp_st, v[i].exp_fv);
            end
        end
    endtask

    task automatic test_stall;
        vec_t v[4];
        v = '{
            '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h04, 32'h0000_0030, 2'd2, 1'b1},
            '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0000_0030, 2'd2, 1'b1},
            '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0000_0030, 2'd2, 1'b1},
            '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0000_0044, 2'd1, 1'b1}
        };
        for (int i = 0; i < 4; i++) begin
            apply(v[i]);
            checks++;
            if ({pc, pc_plus4, state, fetch_valid} !==
                {v[i].exp_pc, v[i].exp_pc + 32'd4, v[i].exp_st, v[i].exp_fv}) begin
                failures++;
                $display("FAIL stall[%0d]: pc=%h p4=%h st=%0d fv=%b, want pc=%h p4=%h st=%0d fv=%b",
                         i, pc, pc_plus4, state, fetch_valid,
                         v[i].exp_pc, v[i].exp_pc + 32'd4, v[i].exp_st, v[i].exp_fv);
            end
        end
    endtask

    task automatic test_reset_in_wait;
        vec_t v[6];
        v = '{
            '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFE, 32'h0000_0040, 2'd1, 1'b1},
            '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h05, 32'h0000_0040, 2'd2, 1'b1},
            '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h05, 32'h0000_0000, 2'd0, 1'b0},
            '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0000_0000, 2'd1, 1'b1},
            '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0000_0004, 2'd1, 1'b1},
            '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0000_0008, 2'd1, 1'b1}
        };
        for (int i = 0; i < 6; i++) begin
            apply(v[i]);
            checks++;
            if ({pc, pc_plus4, state, fetch_valid} !==
                {v[i].exp_pc, v[i].exp_pc + 32'd4, v[i].exp_st, v[i].exp_fv}) begin
                failures++;
                $display("FAIL rst_wait[%0d]: pc=%h p4=%h st=%0d fv=%b, want pc=%h p4=%h st=%0d fv=%b",
                         i, pc, pc_plus4, state, fetch_valid,
                         v[i].exp_pc, v[i].exp_pc + 32'd4, v[i].exp_st, v[i].exp_fv);
            end
        end
    endtask

    task automatic test_wrap;
        vec_t v[5];
        v = '{
            '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFB, 32'hFFFF_FFF8, 2'd1, 1'b1},
            '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'hFFFF_FFFC, 2'd1, 1'b1},
            '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0000_0000, 2'd1, 1'b1},
            '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFF, 32'h0000_0000, 2'd1, 1'b1},
            '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h7F, 32'h0000_0200, 2'd1, 1'b1}
        };
        for (int i = 0; i < 5; i++) begin
            apply(v[i]);
            checks++;
            if ({pc, pc_plus4, state, fetch_valid} !==
                {v[i].exp_pc, v[i].exp_pc + 32'd4, v[i].exp_st, v[i].exp_fv}) begin
                failures++;
                $display("FAIL wrap[%0d]: pc=%h p4=%h st=%0d fv=%b, want pc=%h p4=%h st=%0d fv=%b",
                         i, pc, pc_plus4, state, fetch_valid,
                         v[i].exp_pc, v[i].exp_pc + 32'd4, v[i].exp_st, v[i].exp_fv);
            end
        end
    endtask

    task automatic test_back_to_back;
        vec_t v[6];
        v = '{
            '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h01, 32'h0000_0200, 2'd2, 1'b1},
            '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 32'h0000_0200, 2'd2, 1'b1},
            '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0000_0208, 2'd1, 1'b1},
            '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0000_0208, 2'd2, 1'b1},
            '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h10, 32'h0000_020C, 2'd1, 1'b1},
            '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0000_0210, 2'd1, 1'b1}
        };
        for (int i = 0; i < 6; i++) begin
            apply(v[i]);
            checks++;
            if ({pc, pc_plus4, state, fetch_valid} !==
                {v[i].exp_pc, v[i].exp_pc + 32'd4, v[i].exp_st, v[i].exp_fv}) begin
                failures++;
                $display("FAIL b2b[%0d]: pc=%h p4=%h st=%0d fv=%b, want pc=%h p4=%h st=%0d fv=%b",
                         i, pc, pc_plus4, state, fetch_valid,
                         v[i].exp_pc, v[i].exp_pc + 32'd4, v[i].exp_st, v[i].exp_fv);
            end
        end
    endtask

    initial begin
        reset    = 1'b1;
        busywait = 1'b0;
        jump     = 1'b0;
        branch   = 1'b0;
        zero     = 1'b0;
        offset   = '0;
        @(negedge clk);
        test_reset;
        test_jump;
        test_branch;
        test_stall;
        test_reset_in_wait;
        test_wrap;
        test_back_to_back;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
